// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared constants, FSM state type and line-address helper for
//               the direct-mapped write-back data cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

   localparam int WORD_SIZE  = 16;
   localparam int LINE_WORDS = 4;
   localparam int LINE_BITS  = 64;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2,
      RESPOND   = 2'd3
   } state_t;

   // Word address of the first word of a line: {tag, index, 2'b00}.
   function automatic logic [15:0] line_addr(input logic [15:0] tag,
                                             input logic [15:0] index,
                                             input int          idx_bits);
      logic [15:0] addr;
      addr = (tag << (idx_bits + 2)) | (index << 2);
      return addr;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : dcache_line_store
// Description : Tag/valid/dirty/data arrays of the direct-mapped cache.
//               Combinational lookup, synchronous full-line write or
//               single-word merge, valid/dirty cleared on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int IDX       = 2,
   parameter int TAG_W     = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IDX-1:0]       i_idx,
   output logic                 o_valid,
   output logic                 o_dirty,
   output logic [TAG_W-1:0]     o_tag,
   output logic [LINE_BITS-1:0] o_data,
   input  logic                 i_line_we,
   input  logic [TAG_W-1:0]     i_line_tag,
   input  logic [LINE_BITS-1:0] i_line_data,
   input  logic                 i_line_dirty,
   input  logic                 i_word_we,
   input  logic [1:0]           i_word_off,
   input  logic [WORD_SIZE-1:0] i_word_data,
   input  logic                 i_clr_dirty
);

   logic [NUM_LINES-1:0] r_valid;
   logic [NUM_LINES-1:0] r_dirty;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [LINE_BITS-1:0] r_data [NUM_LINES];

   // Lookup of the addressed line.
   always_comb begin
      o_valid = r_valid[i_idx];
      o_dirty = r_dirty[i_idx];
      o_tag   = r_tag[i_idx];
      o_data  = r_data[i_idx];
   end

   // Status bits: cleared on reset, set by fills and word merges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_line_we) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= i_line_dirty;
      end else if (i_word_we) begin
         r_dirty[i_idx] <= 1'b1;
      end else if (i_clr_dirty) begin
         r_dirty[i_idx] <= 1'b0;
      end
   end

   // Tag and data storage; contents are meaningless while valid is clear.
   always_ff @(posedge clk) begin
      if (i_line_we) begin
         r_tag[i_idx]  <= i_line_tag;
         r_data[i_idx] <= i_line_data;
      end else if (i_word_we) begin
         r_data[i_idx][{i_word_off, 4'b0000} +: WORD_SIZE] <= i_word_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-back, write-allocate data cache between
//               the CPU word port and a multi-cycle 64-bit line memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int NUM_LINES   = 4,
   parameter int MEM_LATENCY = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_addr,
   inout  wire  [63:0] mem_data,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count,
   output logic [15:0] wb_count
);

   localparam int IDX   = $clog2(NUM_LINES);
   localparam int TAG_W = 16 - IDX - 2;
   localparam int CNT_W = $clog2(MEM_LATENCY);
   localparam logic [CNT_W-1:0] C_LAT_M1 = CNT_W'(MEM_LATENCY - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt,      w_cnt_nxt;
   logic [15:0]          r_rdata,    w_rdata_nxt;
   logic                 r_ready,    w_ready_nxt;
   logic                 r_mem_rd,   w_mem_rd_nxt;
   logic                 r_mem_wr,   w_mem_wr_nxt;
   logic [15:0]          r_mem_addr, w_mem_addr_nxt;
   logic [63:0]          r_wb_data,  w_wb_data_nxt;
   logic [15:0]          r_hit_cnt, r_miss_cnt, r_wb_cnt;
   logic                 w_hit_inc, w_miss_inc, w_wb_inc;

   logic [1:0]           w_off;
   logic [IDX-1:0]       w_idx;
   logic [TAG_W-1:0]     w_tag;
   logic                 w_valid, w_dirty, w_hit;
   logic [TAG_W-1:0]     w_vtag;
   logic [63:0]          w_vdata;
   logic [63:0]          w_fill_line;
   logic                 w_line_we, w_word_we, w_clr_dirty;

   assign w_off = cpu_addr[1:0];
   assign w_idx = cpu_addr[IDX+1:2];
   assign w_tag = cpu_addr[15:IDX+2];
   assign w_hit = w_valid && (w_vtag == w_tag);

   // The line bus is only driven while a write-back is being presented.
   assign mem_data = r_mem_wr ? r_wb_data : 64'bz;

   assign cpu_rdata  = r_rdata;
   assign cpu_ready  = r_ready;
   assign mem_read   = r_mem_rd;
   assign mem_write  = r_mem_wr;
   assign mem_addr   = r_mem_addr;
   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
   assign wb_count   = r_wb_cnt;

   dcache_line_store #(
      .NUM_LINES (NUM_LINES),
      .IDX       (IDX),
      .TAG_W     (TAG_W)
   ) u_store (
      .clk          (clk),
      .reset        (reset),
      .i_idx        (w_idx),
      .o_valid      (w_valid),
      .o_dirty      (w_dirty),
      .o_tag        (w_vtag),
      .o_data       (w_vdata),
      .i_line_we    (w_line_we),
      .i_line_tag   (w_tag),
      .i_line_data  (w_fill_line),
      .i_line_dirty (cpu_we),
      .i_word_we    (w_word_we),
      .i_word_off   (w_off),
      .i_word_data  (cpu_wdata),
      .i_clr_dirty  (w_clr_dirty)
   );

   // Incoming fill line with a pending CPU write already merged in.
   always_comb begin
      w_fill_line = mem_data;
      if (cpu_we) begin
         w_fill_line[{w_off, 4'b0000} +: 16] = cpu_wdata;
      end
   end

   // Next-state and next-output logic of the controller FSM.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_rdata_nxt    = r_rdata;
      w_ready_nxt    = 1'b0;
      w_mem_rd_nxt   = r_mem_rd;
      w_mem_wr_nxt   = r_mem_wr;
      w_mem_addr_nxt = r_mem_addr;
      w_wb_data_nxt  = r_wb_data;
      w_hit_inc      = 1'b0;
      w_miss_inc     = 1'b0;
      w_wb_inc       = 1'b0;
      w_line_we      = 1'b0;
      w_word_we      = 1'b0;
      w_clr_dirty    = 1'b0;
      case (r_state)
         IDLE: begin
            if (cpu_req) begin
               if (w_hit) begin
                  w_hit_inc   = 1'b1;
                  w_word_we   = cpu_we;
                  w_rdata_nxt = cpu_we ? cpu_wdata
                                       : w_vdata[{w_off, 4'b0000} +: 16];
                  w_ready_nxt = 1'b1;
                  w_state_nxt = RESPOND;
               end else begin
                  w_miss_inc = 1'b1;
                  w_cnt_nxt  = C_LAT_M1;
                  if (w_valid && w_dirty) begin
                     w_mem_wr_nxt   = 1'b1;
                     w_mem_addr_nxt = line_addr(16'(w_vtag), 16'(w_idx), IDX);
                     w_wb_data_nxt  = w_vdata;
                     w_state_nxt    = WRITEBACK;
                  end else begin
                     w_mem_rd_nxt   = 1'b1;
                     w_mem_addr_nxt = line_addr(16'(w_tag), 16'(w_idx), IDX);
                     w_state_nxt    = FILL;
                  end
               end
            end
         end
         WRITEBACK: begin
            if (r_cnt == '0) begin
               w_mem_wr_nxt   = 1'b0;
               w_clr_dirty    = 1'b1;
               w_wb_inc       = 1'b1;
               w_mem_rd_nxt   = 1'b1;
               w_mem_addr_nxt = line_addr(16'(w_tag), 16'(w_idx), IDX);
               w_cnt_nxt      = C_LAT_M1;
               w_state_nxt    = FILL;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         FILL: begin
            if (r_cnt == '0) begin
               w_mem_rd_nxt = 1'b0;
               w_line_we    = 1'b1;
               w_rdata_nxt  = cpu_we ? cpu_wdata
                                     : mem_data[{w_off, 4'b0000} +: 16];
               w_ready_nxt  = 1'b1;
               w_state_nxt  = RESPOND;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         RESPOND: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered outputs, latency counter and memory-side holding registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_rdata    <= '0;
         r_ready    <= 1'b0;
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         r_mem_addr <= '0;
         r_wb_data  <= '0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_rdata    <= w_rdata_nxt;
         r_ready    <= w_ready_nxt;
         r_mem_rd   <= w_mem_rd_nxt;
         r_mem_wr   <= w_mem_wr_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_wb_data  <= w_wb_data_nxt;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_wb_cnt   <= '0;
      end else begin
         if (w_hit_inc && (r_hit_cnt != 16'hFFFF)) begin
            r_hit_cnt <= r_hit_cnt + 16'd1;
         end
         if (w_miss_inc && (r_miss_cnt != 16'hFFFF)) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
         end
         if (w_wb_inc && (r_wb_cnt != 16'hFFFF)) begin
            r_wb_cnt <= r_wb_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Self-checking bench for dcache_controller: line memory model,
//               cache-behaviour reference model, directed and random accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

   localparam int L  = 6;
   localparam int NL = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   wire  [63:0] mem_data;
   logic [15:0] hit_count, miss_count, wb_count;

   always #5 clk = ~clk;

   dcache_controller #(
      .NUM_LINES   (NL),
      .MEM_LATENCY (L)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .wb_count   (wb_count)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Backing line memory and the "latest value written by the CPU" view.
   logic [15:0] mem  [65536];
   logic [15:0] gold [65536];
   logic [63:0] tb_line;

   always_comb begin
      tb_line = {mem[mem_addr + 16'd3], mem[mem_addr + 16'd2],
                 mem[mem_addr + 16'd1], mem[mem_addr]};
   end
   assign mem_data = mem_read ? tb_line : 64'bz;

   // Cache reference model: which line is resident and whether it is dirty.
   bit          m_valid [NL];
   bit          m_dirty [NL];
   logic [11:0] m_tag   [NL];
   int          e_hit, e_miss, e_wb;

   // Memory-port monitor: strobe lengths, stability, write-back contents.
   int          rd_len = 0, wr_len = 0, rd_runs = 0, wr_runs = 0;
   logic [15:0] rd_a, wr_a, last_rd_a, last_wr_a;
   logic [63:0] wr_d;

   always @(negedge clk) begin
      if (reset) begin
         rd_len = 0;
         wr_len = 0;
      end else begin
         chk("strobe_excl", 64'(mem_read & mem_write), 64'd0);
         if (mem_read) begin
            if (rd_len == 0) begin
               rd_a = mem_addr;
               chk("rd_align", 64'(mem_addr[1:0]), 64'd0);
            end else begin
               chk("rd_addr_stable", 64'(mem_addr), 64'(rd_a));
            end
            rd_len++;
         end else if (rd_len != 0) begin
            chk("rd_len", 64'(rd_len), 64'(L));
            rd_runs++;
            last_rd_a = rd_a;
            rd_len = 0;
         end
         if (mem_write) begin
            if (wr_len == 0) begin
               wr_a = mem_addr;
               wr_d = mem_data;
               chk("wr_align", 64'(mem_addr[1:0]), 64'd0);
            end else begin
               chk("wr_addr_stable", 64'(mem_addr), 64'(wr_a));
               chk("wr_data_stable", mem_data, wr_d);
            end
            wr_len++;
         end else if (wr_len != 0) begin
            chk("wr_len", 64'(wr_len), 64'(L));
            for (int k = 0; k < 4; k++) begin
               chk("wb_data", 64'(wr_d[16*k +: 16]), 64'(gold[wr_a + 16'(k)]));
               mem[wr_a + 16'(k)] = wr_d[16*k +: 16];
            end
            wr_runs++;
            last_wr_a = wr_a;
            wr_len = 0;
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < NL; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
      end
      e_hit = 0; e_miss = 0; e_wb = 0;
      // Unwritten-back CPU writes are lost: memory is the truth again.
      for (int i = 0; i < 65536; i++) gold[i] = mem[i];
   endtask

   task automatic check_counters();
      chk("hit_count",  64'(hit_count),  64'(e_hit));
      chk("miss_count", 64'(miss_count), 64'(e_miss));
      chk("wb_count",   64'(wb_count),   64'(e_wb));
   endtask

   // One CPU access, started in an IDLE cycle, checked against the model.
   task automatic do_access(input bit we, input logic [15:0] a, input logic [15:0] wd);
      int          idx, n, exp_lat, rd0, wr0;
      logic [11:0] tag;
      bit          hit, dmiss;
      logic [15:0] exp_rd, victim;
      idx     = int'(a[3:2]);
      tag     = a[15:4];
      hit     = m_valid[idx] && (m_tag[idx] == tag);
      dmiss   = !hit && m_valid[idx] && m_dirty[idx];
      exp_lat = hit ? 1 : (dmiss ? 2 * L + 1 : L + 1);
      victim  = {m_tag[idx], a[3:2], 2'b00};
      exp_rd  = we ? wd : gold[a];
      rd0 = rd_runs;
      wr0 = wr_runs;
      cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
      n = 0;
      for (int i = 1; i <= 4 * L + 8; i++) begin
         @(posedge clk); #1;
         if (cpu_ready) begin
            n = i;
            break;
         end
      end
      chk("latency", 64'(n), 64'(exp_lat));
      chk("rdata", 64'(cpu_rdata), 64'(exp_rd));
      if (we) gold[a] = wd;
      if (hit) begin
         e_hit++;
         if (we) m_dirty[idx] = 1'b1;
      end else begin
         e_miss++;
         if (dmiss) e_wb++;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
         m_dirty[idx] = we;
      end
      cpu_req = 1'b0;
      @(posedge clk); #1;
      chk("ready_pulse", 64'(cpu_ready), 64'd0);
      check_counters();
      chk("fill_count", 64'(rd_runs - rd0), hit ? 64'd0 : 64'd1);
      chk("wb_count_port", 64'(wr_runs - wr0), dmiss ? 64'd1 : 64'd0);
      if (!hit) chk("fill_addr", 64'(last_rd_a), 64'({a[15:2], 2'b00}));
      if (dmiss) chk("wb_addr", 64'(last_wr_a), 64'(victim));
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[16'h0041] = 16'hF01C;
      mem[16'h0043] = 16'hF01C;
      model_reset();

      // Reset state.
      #2;
      chk("rst_ready", 64'(cpu_ready), 64'd0);
      chk("rst_rdata", 64'(cpu_rdata), 64'd0);
      chk("rst_mem_read", 64'(mem_read), 64'd0);
      chk("rst_mem_write", 64'(mem_write), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      check_counters();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed sequence.
      do_access(1'b0, 16'h0041, 16'h0);
      chk("t1_rdata", 64'(cpu_rdata), 64'hF01C);
      do_access(1'b0, 16'h0043, 16'h0);
      do_access(1'b1, 16'h0042, 16'hBEEF);
      do_access(1'b0, 16'h0042, 16'h0);
      chk("t3_rdata", 64'(cpu_rdata), 64'hBEEF);
      do_access(1'b0, 16'h0050, 16'h0);
      do_access(1'b1, 16'h0084, 16'h1234);
      do_access(1'b0, 16'h0084, 16'h0);
      chk("t5_rdata", 64'(cpu_rdata), 64'h1234);

      // Reset in the third FILL cycle aborts the transaction.
      cpu_we = 1'b0; cpu_addr = 16'h0090; cpu_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (mem_read) break;
      end
      chk("t6_fill_started", 64'(mem_read), 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("t6_mem_read_drop", 64'(mem_read), 64'd0);
      chk("t6_mem_write", 64'(mem_write), 64'd0);
      chk("t6_ready", 64'(cpu_ready), 64'd0);
      chk("t6_mem_addr", 64'(mem_addr), 64'd0);
      model_reset();
      check_counters();
      cpu_req = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      do_access(1'b0, 16'h0041, 16'h0);
      chk("t6_rdata", 64'(cpu_rdata), 64'hF01C);

      // Random accesses over four tags per index to mix hits and misses.
      for (int t = 0; t < 300; t++) begin
         do_access(1'($urandom_range(0, 1)),
                   16'h0100 | 16'($urandom_range(0, 63)),
                   16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller. It sits between the CPU data port and port 2 of the multi-cycle line memory.
- It is the initiator for that memory's line protocol: it asserts mem_read or mem_write, holds the address and data stable for a fixed latency, then captures or retires a 64-bit, 4-word line.
- CPU-side accesses are single 16-bit words, with a one-cycle response pulse.

Parameters:
- NUM_LINES, 4: number of cache lines; power of 2, minimum 2. IDX = log2(NUM_LINES).
- MEM_LATENCY, 6: cycles each memory transaction is held before it completes; minimum 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; held with fields stable until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_read  out  1  line read request (memory readM2).
- mem_write  out  1  line write request (memory writeM2).
- mem_addr  out  16  line address; bits [1:0] always 0.
- mem_data  inout  64  line bus. Driven only while mem_write=1, otherwise high-Z. Word k occupies bits [16k+15:16k].
- hit_count  out  16  hits since reset; saturates at 0xFFFF.
- miss_count  out  16  misses since reset; saturates at 0xFFFF.
- wb_count  out  16  dirty write-backs since reset; saturates at 0xFFFF.

Behaviour:
- Address split: offset = cpu_addr[1:0], index = cpu_addr[IDX+1:2], tag = cpu_addr[15:IDX+2].
- Each line holds a valid bit, a dirty bit, a tag and 4 words.
- Reset (asynchronous, acts immediately):
  - all valid and dirty bits cleared; state IDLE; counters 0.
  - cpu_ready=0, cpu_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_data released to high-Z.
  - Reset during WRITEBACK or FILL aborts the transaction: the memory strobes drop that same instant and no line is updated.
- States: IDLE, WRITEBACK, FILL, RESPOND.
- IDLE, cpu_req=0: nothing happens.
- IDLE, cpu_req=1, hit (valid and tag match):
  - Read: word latched into cpu_rdata.
  - Write: word merged into the line and dirty set; cpu_rdata = cpu_wdata.
  - hit_count increments; go to RESPOND.
- IDLE, cpu_req=1, miss:
  - miss_count increments.
  - Dirty victim: go to WRITEBACK, mem_addr = {victim tag, index, 2'b00}, mem_data = victim line.
  - Otherwise: go to FILL, mem_addr = {tag, index, 2'b00}.
- WRITEBACK:
  - mem_write=1 for exactly MEM_LATENCY cycles; mem_addr and mem_data constant throughout (any change restarts the memory's count).
  - On exit: dirty cleared, wb_count increments, go to FILL with the new line address.
- FILL:
  - mem_read=1 for exactly MEM_LATENCY cycles.
  - On the posedge ending the last cycle: mem_data captured into the line, tag written, valid=1.
  - Then the pending access is performed exactly as on a hit (a write sets dirty); go to RESPOND.
- The memory strobes never overlap; mem_read and mem_write are never both 1.
- Latency counter is loaded with MEM_LATENCY-1 on state entry, decrements each cycle, and the state exits at 0.
- RESPOND: cpu_ready=1 for one cycle; cpu_req is ignored; return to IDLE. A request can therefore be accepted at most every 2 cycles.
- Latency, counted from the IDLE acceptance cycle T:
  - hit: cpu_ready in T+1.
  - clean miss: FILL T+1..T+MEM_LATENCY, cpu_ready in T+MEM_LATENCY+1.
  - dirty miss: cpu_ready in T+2*MEM_LATENCY+1.
- cpu_req dropped before cpu_ready is a protocol violation; the behaviour is undefined.
- Counter saturation: a counter at 0xFFFF holds at 0xFFFF.

Decomposition:
- Package dcache_pkg:
  - constants WORD_SIZE=16, LINE_WORDS=4, LINE_BITS=64.
  - state enum {IDLE, WRITEBACK, FILL, RESPOND}.
  - function line_addr(tag, index).
- Sub-module dcache_line_store:
  - holds the tag, valid, dirty and data arrays.
  - combinational lookup on index.
  - synchronous full-line write and single-word merge.
  - clear-all on reset.
  - The FSM, counters and memory interface remain in dcache_controller.

Test Plan:
1. Reset, then read 0x0041 (memory word 0x41 = 0xF01C) -> mem_read=1 for exactly 6 cycles with mem_addr=0x0040; cpu_ready 7 cycles after acceptance; cpu_rdata=0xF01C; miss_count=1; mem_write never asserted.
2. Then read 0x0043 -> no memory activity; cpu_ready in the next cycle; cpu_rdata=0xF01C; hit_count=1.
3. Write 0x0042 with 0xBEEF, then read 0x0042 -> both are hits with no memory traffic; the read returns 0xBEEF; the line is dirty.
4. Read 0x0050 (same index 0):
   - mem_write=1 for 6 cycles with mem_addr=0x0040 and mem_data[47:32]=0xBEEF, stable.
   - Then mem_read for 6 cycles with mem_addr=0x0050.
   - cpu_ready 13 cycles after acceptance; wb_count=1; miss_count=2.
5. Write 0x0084 with 0x1234 on a clean miss -> fill only, no mem_write; line dirty; a following read of 0x0084 hits and returns 0x1234.
6. Assert reset in the 3rd FILL cycle -> mem_read drops immediately and the counters clear; after release, a read of 0x0041 misses again.
